// File: rtl/sdram_read_capture.sv
// SDRAM read-data capture: CAS/DQM latency alignment, a captured-word FIFO and a registered head.
// Optional running checksum of popped words is enabled by the READ_CAPTURE_CHECKSUM_EN macro.
module sdram_read_capture #(
  parameter int CAS_LATENCY = 2,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_ras,
  input  logic        cmd_cas,
  input  logic        cmd_we,
  input  logic [1:0]  cmd_bank,
  input  logic [12:0] cmd_addr,
  input  logic [1:0]  cmd_dqm,
  input  logic [15:0] dq_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [1:0]  out_bank,
  output logic [9:0]  out_col,
  output logic [1:0]  out_lanes,
  output logic        overflow,
  input  logic        clear_ovf,
  output logic [1:0]  in_flight
`ifdef READ_CAPTURE_CHECKSUM_EN
  ,
  output logic [15:0] checksum
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic       vld;
    logic [1:0] bank;
    logic [9:0] col;
    logic [1:0] lanes;
  } pipe_t;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  bank;
    logic [9:0]  col;
    logic [1:0]  lanes;
  } entry_t;

  pipe_t   pipe_q [CAS_LATENCY];
  pipe_t   pipe_d [CAS_LATENCY];
  entry_t  mem_q  [FIFO_DEPTH];
  entry_t  mem_d  [FIFO_DEPTH];
  entry_t  head_q, head_d;
  entry_t  cap_entry;
  logic    out_valid_q, out_valid_d;
  logic    overflow_q, overflow_d;
  logic [1:0]    in_flight_q, in_flight_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] mem_cnt_q, mem_cnt_d, total_cnt;
  logic    rd_cmd, cap_vld, pop, full, push_ok, load;
  logic    unused_addr;

  // addr[10] is auto-precharge and addr[12:11] are row-only bits; neither affects capture.
  assign unused_addr = ^cmd_addr[12:10];

  assign rd_cmd    = !cmd_ras && cmd_cas && !cmd_we;
  assign cap_vld   = pipe_q[CAS_LATENCY-1].vld;
  assign pop       = out_valid_q && out_ready;
  assign total_cnt = mem_cnt_q + {{(CW-1){1'b0}}, out_valid_q};
  assign full      = (total_cnt == CW'(FIFO_DEPTH));
  assign push_ok   = cap_vld && (!full || pop);
  assign load      = (mem_cnt_q != '0) && (!out_valid_q || pop);

  always_comb begin
    cap_entry.bank  = pipe_q[CAS_LATENCY-1].bank;
    cap_entry.col   = pipe_q[CAS_LATENCY-1].col;
    cap_entry.lanes = pipe_q[CAS_LATENCY-1].lanes;
    cap_entry.data  = {cap_entry.lanes[1] ? dq_in[15:8] : 8'h00,
                       cap_entry.lanes[0] ? dq_in[7:0]  : 8'h00};
  end

  // DQM read latency is 2, so the lane mask joins the tag CAS_LATENCY-2 stages into the pipe.
  always_comb begin
    pipe_d[0] = '{vld: rd_cmd, bank: cmd_bank, col: cmd_addr[9:0], lanes: 2'b00};
    for (int i = 1; i < CAS_LATENCY; i++) pipe_d[i] = pipe_q[i-1];
    pipe_d[CAS_LATENCY-2].lanes = ~cmd_dqm;
  end

  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    mem_cnt_d = mem_cnt_q;
    head_d    = head_q;
    out_valid_d = out_valid_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = cap_entry;
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (load) begin
      head_d      = mem_q[rd_ptr_q];
      rd_ptr_d    = rd_ptr_q + PW'(1);
      out_valid_d = 1'b1;
    end else if (pop) begin
      out_valid_d = 1'b0;
    end
    case ({push_ok, load})
      2'b10:   mem_cnt_d = mem_cnt_q + CW'(1);
      2'b01:   mem_cnt_d = mem_cnt_q - CW'(1);
      default: mem_cnt_d = mem_cnt_q;
    endcase
  end

  always_comb begin
    overflow_d = overflow_q;
    if (cap_vld && full && !pop) overflow_d = 1'b1;
    else if (clear_ovf)          overflow_d = 1'b0;
    in_flight_d = in_flight_q;
    if (rd_cmd && !cap_vld && in_flight_q != 2'd3)      in_flight_d = in_flight_q + 2'd1;
    else if (!rd_cmd && cap_vld && in_flight_q != 2'd0) in_flight_d = in_flight_q - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CAS_LATENCY; i++) pipe_q[i] <= '0;
      head_q      <= '0;
      out_valid_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_cnt_q   <= '0;
      overflow_q  <= 1'b0;
      in_flight_q <= 2'd0;
    end else begin
      for (int i = 0; i < CAS_LATENCY; i++) pipe_q[i] <= pipe_d[i];
      head_q      <= head_d;
      out_valid_q <= out_valid_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_cnt_q   <= mem_cnt_d;
      overflow_q  <= overflow_d;
      in_flight_q <= in_flight_d;
    end
  end

  // Storage needs no reset: the pointers and count decide what is ever read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
  end

  assign out_valid = out_valid_q;
  assign out_data  = head_q.data;
  assign out_bank  = head_q.bank;
  assign out_col   = head_q.col;
  assign out_lanes = head_q.lanes;
  assign overflow  = overflow_q;
  assign in_flight = in_flight_q;

`ifdef READ_CAPTURE_CHECKSUM_EN
  logic [15:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (pop) checksum_d = {checksum_q[14:0], checksum_q[15]} ^ head_q.data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) checksum_q <= 16'h0000;
    else        checksum_q <= checksum_d;
  end

  assign checksum = checksum_q;
`endif

endmodule

// File: doc/sdram_read_capture.md
Name: sdram_read_capture

Overview:
- Sits directly downstream of the SDRAM command sequencer.
- Watches the decoded command bus that the sequencer drives (RAS/CAS/WE, bank, address, DQM) and the DQ pins.
- Applies the CAS-latency and DQM-latency delays and captures read data into a small FIFO.
- Presents captured words, tagged with bank and column, to a consumer over a valid/ready handshake. Burst length 1 only.

Parameters:
- CAS_LATENCY, 2, cycles from READ command to data on DQ; legal values 2..3.
- FIFO_DEPTH, 8, captured-word FIFO entries; power of two, 2..64.

Ports:
- clk  in  1  100 MHz system clock, same clock as DRAM_CLK.
- rst_n  in  1  synchronous active-low reset.
- cmd_ras  in  1  active-high RAS as driven by the sequencer (DRAM_RAS_N inverted).
- cmd_cas  in  1  active-high CAS.
- cmd_we  in  1  active-high WE.
- cmd_bank  in  2  bank address of the current command.
- cmd_addr  in  13  address bus; [9:0] = column, [10] = auto-precharge.
- cmd_dqm  in  2  {UDQM, LDQM} currently driven.
- dq_in  in  16  DRAM_DQ as seen at the pins.
- out_valid  out  1  FIFO head holds a captured word.
- out_ready  in  1  consumer accepts the head this cycle.
- out_data  out  16  captured word; masked byte lanes forced to 0.
- out_bank  out  2  bank of the read.
- out_col  out  10  column of the read.
- out_lanes  out  2  {upper, lower} lane-valid; 1 = lane was driven by SDRAM.
- overflow  out  1  sticky; a capture was dropped because the FIFO was full.
- clear_ovf  in  1  clears overflow.
- in_flight  out  2  reads issued but not yet captured.

Behaviour:
- Reset, on any clk edge with rst_n=0:
  - out_valid=0, out_data/out_bank/out_col/out_lanes=0, overflow=0, in_flight=0.
  - FIFO emptied; latency pipeline flushed.
  - Reads in flight when reset is asserted are discarded and never captured.
- Read detect: edge k with cmd_ras=0, cmd_cas=1, cmd_we=0. Tag = {cmd_bank, cmd_addr[9:0]}.
  - addr[10] is ignored.
  - Any other command, including NOP, is not a read.
- Latency pipeline: shift register of depth CAS_LATENCY carrying {valid, tag}.
- Lane mask: DQM has 2-cycle read latency.
  - out_lanes = ~cmd_dqm sampled at edge k+CAS_LATENCY-2.
  - For CL=2 this is the read cycle's own DQM; for CL=3 it is the cycle after.
- Capture: dq_in sampled at edge k+CAS_LATENCY.
  - Masked lanes are stored as 8'h00.
  - Entry {data, tag, lanes} is pushed at that same edge.
- Back-to-back reads at k, k+1, k+2 are captured at consecutive edges; there are no bubbles.
- FIFO behaviour:
  - Head is registered; out_valid=1 the cycle after the first push into an empty FIFO.
  - Pop occurs when out_valid && out_ready.
  - Push and pop on the same edge: count unchanged, order preserved.
  - Push when full with no pop: entry dropped, overflow set next cycle.
  - Push when full with a simultaneous pop: push accepted, no overflow.
  - Pop when empty: ignored.
- overflow:
  - Set has priority over clear_ovf on the same edge.
  - Otherwise held until clear_ovf or reset.
- in_flight: increments on a read detect, decrements on capture (pushed or dropped). Both on the same edge leaves it unchanged. Saturates at 3.
- Commands on the bus while in_flight>0 do not affect capture; the pipeline is purely time-based.

Optional Feature:
- Macro: READ_CAPTURE_CHECKSUM_EN.
- When defined, the block adds an output checksum[15:0], reset 0.
  - On each pop: checksum <= {checksum[14:0], checksum[15]} ^ out_data.
- When undefined, the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Single read: CL=2, READ bank0 col100 with DQM=00 at edge k; dq_in=16'hDEAD at k+2; out_ready=1.
  - Expect out_valid at k+3 with data DEAD, bank 0, col 100, lanes 11.
  - in_flight goes 1→0.
- Back-to-back reads: READ col100, READ col101, READ col110 on consecutive edges; dq_in = DEAD, BEEF, F00D.
  - Expect three entries in order, each valid for one cycle with out_ready=1.
- Lane masking: READ col99 with DQM=2'b01; dq_in=16'hFACE.
  - Expect data 16'hFA00, lanes 2'b10.
- Overflow: out_ready=0, then 9 reads with data 0..8.
  - Expect 8 entries (0..7), overflow=1, word 8 lost.
  - Then clear_ovf pulse → overflow=0.
- Full with push and pop on the same edge: FIFO full, out_ready=1 on the edge a 9th capture lands.
  - Expect overflow=0 and the 9th word present at the tail.
- Reset mid-flight: READ at k, rst_n=0 at k+1, data driven at k+2.
  - Expect no entry, out_valid=0, in_flight=0.
- CL=3 variant: DQM=11 on the read cycle, 00 on the cycle after.
  - Expect lanes 11 and data captured at k+3.
